// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
package wb_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] v;
      v       = '0;
      v[addr] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; exposes per-entry valid bits and
// destination addresses so the top level can build the pending-write mask.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                   i_clk,
   input  logic                                   i_reset,
   input  logic                                   i_push,
   input  wb_entry_t                              i_push_entry,
   input  logic                                   i_pop,
   output logic                                   o_full,
   output logic                                   o_empty,
   output logic [$clog2(FIFO_DEPTH):0]            o_count,
   output wb_entry_t                              o_head,
   output logic [FIFO_DEPTH-1:0]                  o_entry_valid,
   output logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]  o_entry_addr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   wb_entry_t             r_mem [FIFO_DEPTH];
   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;
   logic [FIFO_DEPTH-1:0] r_valid;
   logic [AW-1:0]         w_wr_idx;
   logic [AW-1:0]         w_rd_idx;
   logic                  w_push_ok;
   logic                  w_pop_ok;
   logic [FIFO_DEPTH-1:0] w_set;
   logic [FIFO_DEPTH-1:0] w_clr;

   // Extra MSB on the pointers separates full (MSBs differ) from empty.
   assign w_wr_idx  = r_wr_ptr[AW-1:0];
   assign w_rd_idx  = r_rd_ptr[AW-1:0];
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_head    = r_mem[w_rd_idx];
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign w_set     = {{(FIFO_DEPTH-1){1'b0}}, w_push_ok} << w_wr_idx;
   assign w_clr     = {{(FIFO_DEPTH-1){1'b0}}, w_pop_ok} << w_rd_idx;
   assign o_entry_valid = r_valid;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_valid  <= '0;
      end else begin
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         // Clear before set: a full-FIFO push/pop hits the same slot.
         r_valid <= (r_valid & ~w_clr) | w_set;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[w_wr_idx] <= i_push_entry;
   end

   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_addr
      assign o_entry_addr[gi] = r_mem[gi].addr;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Serializes ALU and buffered LSU results onto the single register-file write port.
// Optional macro WB_BYPASS_EN lets an LSU result skip an empty FIFO when the ALU is idle.
module regfile_wb_arbiter
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_alu_valid,
   output logic                        o_alu_ready,
   input  logic [REG_ADDR_W-1:0]       i_alu_rd_addr,
   input  logic [XLEN-1:0]             i_alu_rd_data,
   input  logic                        i_lsu_valid,
   output logic                        o_lsu_ready,
   input  logic [REG_ADDR_W-1:0]       i_lsu_rd_addr,
   input  logic [XLEN-1:0]             i_lsu_rd_data,
   output logic [REG_ADDR_W-1:0]       o_rd_addr,
   output logic [XLEN-1:0]             o_rd_data,
   output logic                        o_rd_wren,
   output logic [NUM_REGS-1:0]         o_busy_mask,
   output logic [$clog2(FIFO_DEPTH):0] o_lsu_count
);

   logic                                  w_full;
   logic                                  w_empty;
   logic                                  w_pop;
   logic                                  w_push;
   logic                                  w_alu_wr;
   logic                                  w_lsu_fire;
   logic                                  w_lsu_nz;
   logic                                  w_bypass;
   wb_entry_t                             w_head;
   wb_entry_t                             w_lsu_entry;
   logic [FIFO_DEPTH-1:0]                 w_entry_valid;
   logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] w_entry_addr;
   logic [FIFO_DEPTH-1:0][NUM_REGS-1:0]   w_entry_busy;
   logic [NUM_REGS-1:0]                   w_busy;
   logic                                  r_rd_wren;
   logic [REG_ADDR_W-1:0]                 r_rd_addr;
   logic [XLEN-1:0]                       r_rd_data;

   // ALU wins unless the FIFO is full (starvation guard) or the ALU is idle.
   assign w_pop       = !w_empty && (w_full || !i_alu_valid);
   assign o_alu_ready = i_reset && !w_full;
   assign o_lsu_ready = i_reset && (!w_full || w_pop);
   assign w_alu_wr    = i_alu_valid && o_alu_ready && (i_alu_rd_addr != '0);
   assign w_lsu_fire  = i_lsu_valid && o_lsu_ready;
   assign w_lsu_nz    = (i_lsu_rd_addr != '0);
   assign w_lsu_entry = '{addr: i_lsu_rd_addr, data: i_lsu_rd_data};

`ifdef WB_BYPASS_EN
   assign w_bypass = w_lsu_fire && w_lsu_nz && w_empty && !i_alu_valid;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = w_lsu_fire && w_lsu_nz && !w_bypass;

   wb_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_push        (w_push),
      .i_push_entry  (w_lsu_entry),
      .i_pop         (w_pop),
      .o_full        (w_full),
      .o_empty       (w_empty),
      .o_count       (o_lsu_count),
      .o_head        (w_head),
      .o_entry_valid (w_entry_valid),
      .o_entry_addr  (w_entry_addr)
   );

   // Pop, ALU write and bypass are mutually exclusive by construction.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_rd_wren <= 1'b0;
         r_rd_addr <= '0;
         r_rd_data <= '0;
      end else if (w_pop) begin
         r_rd_wren <= 1'b1;
         r_rd_addr <= w_head.addr;
         r_rd_data <= w_head.data;
      end else if (w_alu_wr) begin
         r_rd_wren <= 1'b1;
         r_rd_addr <= i_alu_rd_addr;
         r_rd_data <= i_alu_rd_data;
      end else if (w_bypass) begin
         r_rd_wren <= 1'b1;
         r_rd_addr <= i_lsu_rd_addr;
         r_rd_data <= i_lsu_rd_data;
      end else begin
         r_rd_wren <= 1'b0;
      end
   end

   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_busy
      assign w_entry_busy[gi] = w_entry_valid[gi] ? reg_onehot(w_entry_addr[gi]) : '0;
   end

   always_comb begin
      w_busy = r_rd_wren ? reg_onehot(r_rd_addr) : '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         w_busy = w_busy | w_entry_busy[i];
      end
   end

   assign o_busy_mask = {w_busy[NUM_REGS-1:1], 1'b0};
   assign o_rd_wren   = r_rd_wren;
   assign o_rd_addr   = r_rd_addr;
   assign o_rd_data   = r_rd_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes (with arrival cycle)
// are queued as stimulus is driven and compared as o_rd_wren pulses appear.
module tb_regfile_wb_arbiter;
   import wb_pkg::*;

   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
   logic [4:0]  alu_addr, lsu_addr, rd_addr;
   logic [31:0] alu_data, lsu_data, rd_data, busy_mask;
   logic        rd_wren;
   logic [2:0]  lsu_count;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   bit   mon_en   = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   regfile_wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_alu_valid   (alu_valid),
      .o_alu_ready   (alu_ready),
      .i_alu_rd_addr (alu_addr),
      .i_alu_rd_data (alu_data),
      .i_lsu_valid   (lsu_valid),
      .o_lsu_ready   (lsu_ready),
      .i_lsu_rd_addr (lsu_addr),
      .i_lsu_rd_data (lsu_data),
      .o_rd_addr     (rd_addr),
      .o_rd_data     (rd_data),
      .o_rd_wren     (rd_wren),
      .o_busy_mask   (busy_mask),
      .o_lsu_count   (lsu_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      @(posedge clk);
      #1;
      alu_valid = av; alu_addr = aa; alu_data = ad;
      lsu_valid = lv; lsu_addr = la; lsu_data = ld;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   // Called right after drive(): the write should appear lat cycles later.
   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int lat);
      exp_t x;
      x.addr = a; x.data = d; x.cyc = cyc + lat;
      sb_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (mon_en && rd_wren === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_wr", 32'(rd_wren), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("wr_addr", 32'(rd_addr), 32'(e.addr));
            check("wr_data", rd_data, e.data);
            check("wr_cycle", cyc, e.cyc);
            $display("write x%0d = 0x%08h at cycle %0d", rd_addr, rd_data, cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h3333_3333;
      lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h4444_4444;

      // Reset held 3 cycles with both sources valid
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wren", 32'(rd_wren), 32'd0);
      check("rst_addr", 32'(rd_addr), 32'd0);
      check("rst_data", rd_data, 32'd0);
      check("rst_busy", busy_mask, 32'd0);
      check("rst_count", 32'(lsu_count), 32'd0);
      check("rst_alu_ready", 32'(alu_ready), 32'd0);
      check("rst_lsu_ready", 32'(lsu_ready), 32'd0);
      $display("reset: checked outputs and readies");
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;

      // ALU write to x5
      drive(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0);
      expect_wr(5'd5, 32'h0000_00AA, 1);
      @(negedge clk);
      check("alu_ready", 32'(alu_ready), 32'd1);
      idle();
      @(negedge clk);
      check("alu_wren", 32'(rd_wren), 32'd1);
      check("alu_busy", busy_mask, 32'h0000_0020);
      idle();
      @(negedge clk);
      check("alu_busy_clear", busy_mask, 32'd0);

      // x0 writes are accepted and dropped
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
      @(negedge clk);
      check("x0_alu_ready", 32'(alu_ready), 32'd1);
      check("x0_lsu_ready", 32'(lsu_ready), 32'd1);
      idle();
      @(negedge clk);
      check("x0_wren", 32'(rd_wren), 32'd0);
      check("x0_busy", busy_mask, 32'd0);
      check("x0_count", 32'(lsu_count), 32'd0);
      $display("x0 drop: checked");

      // Fill with ALU busy, then starvation guard
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'(20 + i), 32'(32'hA0 + i), 1'b1, 5'(1 + i), 32'(32'h11 * (i + 1)));
         expect_wr(5'(20 + i), 32'(32'hA0 + i), 1);
      end
      drive(1'b1, 5'd24, 32'h0000_00A4, 1'b0, 5'd0, 32'd0);
      expect_wr(5'd1, 32'h11, 1);
      @(negedge clk);
      check("fill_count", 32'(lsu_count), 32'd4);
      check("fill_alu_ready", 32'(alu_ready), 32'd0);
      check("fill_busy", busy_mask, 32'h0080_001E);
      drive(1'b1, 5'd24, 32'h0000_00A4, 1'b0, 5'd0, 32'd0);
      expect_wr(5'd24, 32'h0000_00A4, 1);
      @(negedge clk);
      check("starve_count", 32'(lsu_count), 32'd3);
      for (int i = 2; i <= 4; i++) begin
         idle();
         expect_wr(5'(i), 32'(32'h11 * i), 1);
      end
      idle();
      @(negedge clk);
      check("drain_count", 32'(lsu_count), 32'd0);
      $display("fill/starvation: checked");

      // Push and pop together on a full FIFO
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'(25 + i), 32'(32'hB0 + i), 1'b1, 5'(6 + i), 32'(32'h101 * (i + 1)));
         expect_wr(5'(25 + i), 32'(32'hB0 + i), 1);
      end
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h0000_0505);
      expect_wr(5'd6, 32'h101, 1);
      @(negedge clk);
      check("full_lsu_ready", 32'(lsu_ready), 32'd1);
      check("full_count", 32'(lsu_count), 32'd4);
      idle();
      expect_wr(5'd7, 32'h202, 1);
      @(negedge clk);
      check("pushpop_count", 32'(lsu_count), 32'd4);
      idle(); expect_wr(5'd8, 32'h303, 1);
      idle(); expect_wr(5'd9, 32'h404, 1);
      idle(); expect_wr(5'd10, 32'h505, 1);
      repeat (2) idle();
      $display("full push/pop: checked");

      // LSU latency into an empty FIFO with the ALU idle
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_1234);
`ifdef WB_BYPASS_EN
      expect_wr(5'd9, 32'h0000_1234, 1);
`else
      expect_wr(5'd9, 32'h0000_1234, 2);
`endif
      repeat (3) idle();
      $display("bypass/latency: checked");

      // Reset mid-operation discards buffered LSU results
      drive(1'b1, 5'd12, 32'h0000_000C, 1'b1, 5'd13, 32'h0000_000D);
      expect_wr(5'd12, 32'h0000_000C, 1);
      drive(1'b1, 5'd14, 32'h0000_000E, 1'b1, 5'd15, 32'h0000_000F);
      expect_wr(5'd14, 32'h0000_000E, 1);
      drive(1'b1, 5'd16, 32'h0000_0016, 1'b0, 5'd0, 32'd0);
      expect_wr(5'd16, 32'h0000_0016, 1);
      @(negedge clk);
      check("pre_rst_count", 32'(lsu_count), 32'd2);
      @(posedge clk);
      #1;
      rst_n = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
      @(negedge clk);
      check("midrst_alu_ready", 32'(alu_ready), 32'd0);
      check("midrst_lsu_ready", 32'(lsu_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_wren", 32'(rd_wren), 32'd0);
      check("midrst_count", 32'(lsu_count), 32'd0);
      check("midrst_busy", busy_mask, 32'd0);
      repeat (4) idle();
      $display("mid-operation reset: checked");

      check("sb_empty", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that drives the single write port of the 32×32 register file (`rd_addr` / `rd_data` / `rd_wren`). It accepts results from two producers over valid/ready handshakes:

- the single-cycle ALU path;
- the variable-latency load/store unit (LSU).

LSU results are buffered in a small FIFO, and the two sources are serialized onto one registered write per cycle. The block also exports a pending-write mask so the issue stage can stall on register hazards.

## Interface
Parameters:
- FIFO_DEPTH, 4, LSU result buffer entries; power of two, ≥2

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  reset, synchronous, active-low
- i_alu_valid  in  1  ALU result valid
- o_alu_ready  out  1  ALU result accepted when valid&ready
- i_alu_rd_addr  in  5  ALU destination register
- i_alu_rd_data  in  32  ALU result
- i_lsu_valid  in  1  LSU result valid
- o_lsu_ready  out  1  LSU result accepted when valid&ready
- i_lsu_rd_addr  in  5  LSU destination register
- i_lsu_rd_data  in  32  LSU load data
- o_rd_addr  out  5  register-file write address (registered)
- o_rd_data  out  32  register-file write data (registered)
- o_rd_wren  out  1  register-file write enable (registered)
- o_busy_mask  out  32  bit r = write to xr pending inside this block
- o_lsu_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- **ALU path:** an accepted ALU result goes straight to the output stage. ALU results are not buffered.
- **LSU path:** an accepted LSU result is pushed into the FIFO.
- **Arbitration each cycle**, among ALU-valid and FIFO-non-empty:
  - The ALU wins by default.
  - The FIFO head wins when the FIFO is full; this is the starvation guard.
  - The FIFO head also wins when the ALU is not valid.
- **Readies:**
  - o_alu_ready = reset deasserted AND NOT (FIFO full).
  - o_lsu_ready = reset deasserted AND (NOT full OR head popped this cycle).
- **Writes to x0:** the handshake completes, but nothing is written.
  - No FIFO push.
  - No o_rd_wren.
  - No busy bit.
- **Simultaneous push and pop on a full FIFO:** both are legal; occupancy is unchanged.
- **Same destination from both sources in one cycle:** the ALU write lands first and the LSU write lands later. Ordering between producers is the issue stage's responsibility, via o_busy_mask.
- **o_busy_mask:** combinational OR of the decoded addresses of all valid FIFO entries and the output stage when o_rd_wren=1. Bit 0 is always 0.
- **o_lsu_count:** equals the number of valid FIFO entries. It never exceeds FIFO_DEPTH.
- **FIFO pointers:** wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.

## Timing
- **Reset** (i_reset=0 at a rising edge):
  - FIFO emptied.
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
  - o_busy_mask=0, o_lsu_count=0.
  - o_alu_ready=0 and o_lsu_ready=0 while i_reset=0.
- **Reset mid-operation:** all buffered LSU results are discarded. No write issues in the following cycle.
- **ALU latency:** accepted in cycle N → o_rd_wren=1 in cycle N+1, held one cycle.
- **LSU latency:** accepted in cycle N → earliest o_rd_wren in cycle N+2 (push in N, pop in N+1).
- **Throughput:** at most one register-file write per cycle. o_rd_wren deasserts in any cycle with no winner.
- **Register-file write timing:** the register file samples on the edge ending the o_rd_wren cycle, so a read in cycle N+2 returns the new value.

## Configuration
- WB_BYPASS_EN:
  - **Defined:** an LSU result skips the FIFO and goes directly to the output stage when all of the following hold in the same cycle:
    - the FIFO is empty;
    - ALU valid is 0;
    - the LSU handshake completes.
    
    LSU latency is then 1 cycle, equal to the ALU path.
  - **Undefined:** every LSU result passes through the FIFO; minimum LSU latency is 2 cycles.

## Structure
- **Package `wb_pkg`:**
  - XLEN=32.
  - REG_ADDR_W=5.
  - wb_entry_t struct {addr[4:0], data[31:0]}.
- **Sub-module `wb_fifo`:**
  - Synchronous FIFO of wb_entry_t, parameterized by FIFO_DEPTH.
  - Ports: push, pop, full, empty, count, head.
  - Exposes its entry-valid bits and addresses for busy-mask generation.
- **Top level:** arbitration, x0 filtering, bypass logic and the output register.

## Test plan
- **Reset:** hold i_reset=0 for 3 cycles with both sources valid → all outputs 0, both readies 0, o_lsu_count=0.
- **ALU write:** ALU writes x5=0x0000_00AA in cycle 1 → o_rd_wren=1, o_rd_addr=5, o_rd_data=0xAA in cycle 2; o_busy_mask=0x20 during cycle 2.
- **x0 drop:** ALU and LSU each target x0 with data 0xFFFF_FFFF → readies high, no o_rd_wren, o_busy_mask stays 0.
- **Fill and starvation guard:**
  - Stimulus: ALU valid every cycle while LSU pushes 4 results (x1..x4 = 0x11..0x44).
  - Response: FIFO reaches count=4, and the FIFO head wins. x1=0x11 is written while o_alu_ready=0.
  - The remaining entries drain in order x2, x3, x4 once the ALU is idle.
- **Simultaneous push and pop on full:** FIFO full and ALU idle; a 5th LSU push coincides with the head pop → o_lsu_ready=1, count stays 4, no data lost.
- **Bypass:**
  - With WB_BYPASS_EN: an LSU write to x9=0x1234 into an empty FIFO with the ALU idle → o_rd_wren in cycle N+1.
  - Without WB_BYPASS_EN: the same stimulus → o_rd_wren in cycle N+2.
